// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the memory stage: op encodings, FSM states and
// the op decode helpers used by the stage and its load aligner.
package mem_stage_hs_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RWAIT = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  // Unknown encodings collapse to NONE so they pass through without RAM traffic.
  function automatic mem_op_e decode_op(input logic [3:0] raw);
    mem_op_e op;
    case (raw)
      4'd1:    op = OP_LB;
      4'd2:    op = OP_LBU;
      4'd3:    op = OP_LH;
      4'd4:    op = OP_LHU;
      4'd5:    op = OP_LW;
      4'd6:    op = OP_SB;
      4'd7:    op = OP_SH;
      4'd8:    op = OP_SW;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Picks the addressed byte/half/word out of a RAM read word and extends it
// to the full data width.
module load_align
  import mem_stage_hs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  off_i,
  input  mem_op_e           op_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] sh_s;

  assign sh_s = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (op_i)
      OP_LB:   data_o = DATA_W'($signed(sh_s[7:0]));
      OP_LBU:  data_o = DATA_W'(sh_s[7:0]);
      OP_LH:   data_o = DATA_W'($signed(sh_s[15:0]));
      OP_LHU:  data_o = DATA_W'(sh_s[15:0]);
      OP_LW:   data_o = DATA_W'($signed(sh_s[31:0]));
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage: valid/ready handshake on both sides and a single
// outstanding request to the data RAM.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_alu_res,
  input  logic [DATA_W-1:0]   in_rt_data,
  input  logic [3:0]          in_mem_op,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_w_reg_ena,
  input  logic                in_wb_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_mem_data,
  output logic [ADDR_W-1:0]   out_alu_res,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_w_reg_ena,
  output logic                out_wb_sel,
  output logic                out_addr_err,
  output logic                ram_req,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_gnt,
  input  logic                ram_rvalid,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  state_e              state_q;
  mem_op_e             op_q;
  logic [OFF_W-1:0]    off_q;
  logic                out_valid_q, out_w_reg_ena_q, out_wb_sel_q, out_addr_err_q;
  logic [DATA_W-1:0]   out_mem_data_q;
  logic [ADDR_W-1:0]   out_alu_res_q;
  logic [RD_W-1:0]     out_rd_q;
  logic                ram_req_q, ram_we_q;
  logic [BE_W-1:0]     ram_be_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;

  mem_op_e             op_s;
  logic [OFF_W-1:0]    off_s;
  logic                misal_s;
  logic                accept_s;
  logic [BE_W-1:0]     be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   load_data_s;

  // A finished result may be replaced in the same cycle it is consumed.
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;

  always_comb begin
    op_s    = decode_op(in_mem_op);
    off_s   = in_alu_res[OFF_W-1:0];
    misal_s = 1'b0;
    be_d    = '0;
    wdata_d = '0;
    case (op_s)
      OP_LB, OP_LBU, OP_SB: begin
        be_d    = BE_W'(1'b1) << off_s;
        wdata_d = {BE_W{in_rt_data[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        misal_s = in_alu_res[0];
        be_d    = BE_W'(2'b11) << off_s;
        wdata_d = {(DATA_W/16){in_rt_data[15:0]}};
      end
      OP_LW, OP_SW: begin
        misal_s = (in_alu_res[1:0] != 2'b00);
        be_d    = BE_W'(4'hF) << off_s;
        wdata_d = {(DATA_W/32){in_rt_data[31:0]}};
      end
      default: be_d = '0;
    endcase
  end

  load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_load_align (
    .rdata_i (ram_rdata),
    .off_i   (off_q),
    .op_i    (op_q),
    .data_o  (load_data_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      op_q            <= OP_NONE;
      off_q           <= '0;
      out_valid_q     <= 1'b0;
      out_w_reg_ena_q <= 1'b0;
      out_wb_sel_q    <= 1'b0;
      out_addr_err_q  <= 1'b0;
      out_mem_data_q  <= '0;
      out_alu_res_q   <= '0;
      out_rd_q        <= '0;
      ram_req_q       <= 1'b0;
      ram_we_q        <= 1'b0;
      ram_be_q        <= '0;
      ram_addr_q      <= '0;
      ram_wdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            op_q           <= op_s;
            off_q          <= off_s;
            out_alu_res_q  <= in_alu_res;
            out_rd_q       <= in_rd;
            out_wb_sel_q   <= in_wb_sel;
            out_mem_data_q <= '0;
            if (op_s == OP_NONE) begin
              out_valid_q     <= 1'b1;
              out_addr_err_q  <= 1'b0;
              out_w_reg_ena_q <= in_w_reg_ena;
            end else if (misal_s) begin
              // Misaligned accesses never reach the RAM and must not write back.
              out_valid_q     <= 1'b1;
              out_addr_err_q  <= 1'b1;
              out_w_reg_ena_q <= 1'b0;
            end else begin
              out_valid_q     <= 1'b0;
              out_addr_err_q  <= 1'b0;
              out_w_reg_ena_q <= in_w_reg_ena;
              ram_req_q       <= 1'b1;
              ram_we_q        <= is_store(op_s);
              ram_be_q        <= be_d;
              ram_addr_q      <= {in_alu_res[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              ram_wdata_q     <= wdata_d;
              state_q         <= S_REQ;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end else begin
            out_valid_q <= out_valid_q;
          end
        end
        S_REQ: begin
          if (ram_gnt) begin
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            if (is_store(op_q)) begin
              out_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              state_q <= S_RWAIT;
            end
          end else begin
            state_q <= S_REQ;
          end
        end
        S_RWAIT: begin
          if (ram_rvalid) begin
            out_mem_data_q <= load_data_s;
            out_valid_q    <= 1'b1;
            state_q        <= S_HOLD;
          end else begin
            state_q <= S_RWAIT;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_HOLD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_mem_data  = out_mem_data_q;
  assign out_alu_res   = out_alu_res_q;
  assign out_rd        = out_rd_q;
  assign out_w_reg_ena = out_w_reg_ena_q;
  assign out_wb_sel    = out_wb_sel_q;
  assign out_addr_err  = out_addr_err_q;
  assign ram_req       = ram_req_q;
  assign ram_we        = ram_we_q;
  assign ram_be        = ram_be_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule
